fft_power_peak: RTL and testbench
=================================

// Module: fft_power_peak
// PURPOSE
//   Downstream consumer of the 256-point FFT output stream. Computes the exact power |X[k]|^2 of
//   each bin and forwards it, tagged with its bin index, to the detection logic. Tracks the
//   per-frame maximum-power bin and reports it once per frame.
//   Sits directly between the FFT core's valid/ready output port and the DOA/peak post-processing.
// PARAMETERS
//   DATA_WIDTH   18   signed width of FFT real/imag samples
//   FFT_SIZE     256  bins per frame (power of two)
//   IDX_WIDTH    8    bin index width, = log2(FFT_SIZE)
//   SKIP_DC      1    1: bin 0 excluded from the peak search (still streamed out)
//   SEARCH_HALF  1    1: peak search limited to bins < FFT_SIZE/2 (real-input symmetry)
// PORTS
//   clk_i          in   1             clock, all logic on posedge
//   rst_i          in   1             synchronous, active-high reset
//   data_real_i    in   DATA_WIDTH    FFT bin real part (signed)
//   data_imag_i    in   DATA_WIDTH    FFT bin imag part (signed)
//   valid_i        in   1             input bin valid
//   ready_o        out  1             block can accept a bin this cycle
//   power_o        out  2*DATA_WIDTH  unsigned re^2+im^2
//   power_bin_o    out  IDX_WIDTH     bin index of power_o
//   power_valid_o  out  1             power_o/power_bin_o valid
//   power_ready_i  in   1             downstream accepts power_o
//   peak_bin_o     out  IDX_WIDTH     max-power bin of last completed frame
//   peak_power_o   out  2*DATA_WIDTH  power of that bin
//   peak_valid_o   out  1             1-cycle pulse: new peak result
// BEHAVIOUR
//   Reset: all registered outputs 0, bin counter 0, pipeline empty, FSM=ACCUM. ready_o=1 after reset.
//   Reset mid-frame discards the partial frame and emits no peak pulse.
//   Handshake:
//   - en = !power_valid_o | power_ready_i; ready_o = en (combinational, global stall).
//   - Accept = valid_i & ready_o. No transfer when en=0; all pipeline registers hold.
//   Pipeline (2 stages, advance on en):
//   - S1 registers re, im, bin, and valid (= accept).
//   - S2 registers power_o = re*re + im*im, power_bin_o, and power_valid_o = S1 valid.
//   - Latency: accept at cycle t -> power_valid_o at t+2 with no backpressure. Throughput 1 bin/cycle.
//   Arithmetic:
//   - Signed squares, unsigned sum, exact, no rounding or saturation.
//   - Max 2^(2*DATA_WIDTH-1) (both parts = -2^(DATA_WIDTH-1)) fits 2*DATA_WIDTH bits.
//   Bin counter: +1 per accept; wraps FFT_SIZE-1 -> 0. Bin 0 is the first sample after reset.
//   Peak search (evaluated on each output transfer, i.e. power_valid_o & power_ready_i):
//   - Eligible bins: bin >= (SKIP_DC?1:0) and, if SEARCH_HALF, bin < FFT_SIZE/2.
//   - The first eligible bin of a frame loads the running max unconditionally.
//   - Later eligible bins replace it only if strictly greater, so ties go to the lowest bin.
//   FSM:
//   - ACCUM -> REPORT on transfer of bin FFT_SIZE-1.
//   - REPORT lasts 1 cycle: peak_bin_o/peak_power_o update, peak_valid_o=1. Then REPORT -> ACCUM.
//   - Peak outputs hold until the next REPORT.
//   - Next frame's bins may transfer during REPORT. A bin-0 (or first eligible) load in that cycle
//     affects only the new running max, not the reported result.
//   Streaming continues regardless of FSM state; the peak logic never back-pressures.
// TESTING
//   1 Frame: bin37=(1000,-2000), all others 0, power_ready_i=1 ->
//     power_o=5000000, bin 37, 2 cycles after accept; peak_valid_o pulse with bin 37, power 5000000.
//   2 Bin 3=(-131072,-131072) -> power_o=34359738368 (2^35) exact; peak bin 3.
//   3 Random bins, power_ready_i random 50% ->
//     exactly 256 outputs, bins 0..255 in order, values match model, ready_o=0 exactly when stalled.
//   4 SKIP_DC=1: bin0 power 9000, bins 10 and 20 both power 500, others 0 -> peak bin 10, power 500.
//   5 SEARCH_HALF=1: bin200 largest, bin5 next -> peak 5. SEARCH_HALF=0 -> peak 200.
//   6 Reset after 100 accepted bins, then a full frame (as test 1) plus the next frame back-to-back ->
//     bins restart at 0; one peak pulse per full frame; no pulse for the aborted frame.

Source files
------------

// File: rtl/fft_power_peak.sv
// Exact bin power |X[k]|^2 for the FFT output stream, tagged with bin index.
// Also tracks the maximum-power bin of each frame and reports it once per frame.
module fft_power_peak #(
  parameter int DATA_WIDTH  = 18,
  parameter int FFT_SIZE    = 256,
  parameter int IDX_WIDTH   = 8,
  parameter int SKIP_DC     = 1,
  parameter int SEARCH_HALF = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   data_real_i,
  input  logic [DATA_WIDTH-1:0]   data_imag_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [2*DATA_WIDTH-1:0] power_o,
  output logic [IDX_WIDTH-1:0]    power_bin_o,
  output logic                    power_valid_o,
  input  logic                    power_ready_i,
  output logic [IDX_WIDTH-1:0]    peak_bin_o,
  output logic [2*DATA_WIDTH-1:0] peak_power_o,
  output logic                    peak_valid_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_BIN = IDX_WIDTH'(FFT_SIZE - 1);
  localparam logic [IDX_WIDTH:0]   HALF_BIN = (IDX_WIDTH + 1)'(FFT_SIZE / 2);

  typedef enum logic {ACCUM, REPORT} state_e;

  // Both squares are non-negative, so the sum of their unsigned views is exact in PW bits.
  function automatic logic [PW-1:0] bin_power(input logic signed [DATA_WIDTH-1:0] re,
                                              input logic signed [DATA_WIDTH-1:0] im);
    logic signed [PW-1:0] re_x, im_x, re_sq, im_sq;
    re_x  = PW'(re);
    im_x  = PW'(im);
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

  function automatic logic bin_eligible(input logic [IDX_WIDTH-1:0] bin);
    logic lo_ok, hi_ok;
    lo_ok = (SKIP_DC == 0) || (bin != '0);
    hi_ok = (SEARCH_HALF == 0) || ({1'b0, bin} < HALF_BIN);
    return lo_ok && hi_ok;
  endfunction

  logic                         en, accept, xfer;
  logic signed [DATA_WIDTH-1:0] re_p1_q, re_p1_d, im_p1_q, im_p1_d;
  logic [IDX_WIDTH-1:0]         bin_p1_q, bin_p1_d;
  logic                         vld_p1_q, vld_p1_d;
  logic [IDX_WIDTH-1:0]         bin_cnt_q, bin_cnt_d;
  logic [PW-1:0]                power_p2_q, power_p2_d;
  logic [IDX_WIDTH-1:0]         bin_p2_q, bin_p2_d;
  logic                         vld_p2_q, vld_p2_d;
  state_e                       state_q, state_d;
  logic                         have_max_q, have_max_d;
  logic [PW-1:0]                max_pow_q, max_pow_d;
  logic [IDX_WIDTH-1:0]         max_bin_q, max_bin_d;
  logic [PW-1:0]                peak_pow_q, peak_pow_d;
  logic [IDX_WIDTH-1:0]         peak_bin_q, peak_bin_d;
  logic                         peak_vld_q, peak_vld_d;
  logic                         max_upd;

  assign en      = !vld_p2_q || power_ready_i;
  assign accept  = valid_i && en;
  assign xfer    = vld_p2_q && power_ready_i;
  assign ready_o = en;

  assign power_o       = power_p2_q;
  assign power_bin_o   = bin_p2_q;
  assign power_valid_o = vld_p2_q;
  assign peak_bin_o    = peak_bin_q;
  assign peak_power_o  = peak_pow_q;
  assign peak_valid_o  = peak_vld_q;

  always_comb begin
    re_p1_d    = re_p1_q;
    im_p1_d    = im_p1_q;
    bin_p1_d   = bin_p1_q;
    vld_p1_d   = vld_p1_q;
    bin_cnt_d  = bin_cnt_q;
    power_p2_d = power_p2_q;
    bin_p2_d   = bin_p2_q;
    vld_p2_d   = vld_p2_q;

    // ---- stage 1: capture accepted bin and its index
    if (en) begin
      vld_p1_d = accept;
      if (accept) begin
        re_p1_d   = data_real_i;
        im_p1_d   = data_imag_i;
        bin_p1_d  = bin_cnt_q;
        bin_cnt_d = (bin_cnt_q == LAST_BIN) ? '0 : bin_cnt_q + 1'b1;
      end
    end

    // ---- stage 2: power; data registers only move when a valid bin arrives
    if (en) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        power_p2_d = bin_power(re_p1_q, im_p1_q);
        bin_p2_d   = bin_p1_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    have_max_d = have_max_q;
    max_pow_d  = max_pow_q;
    max_bin_d  = max_bin_q;
    peak_pow_d = peak_pow_q;
    peak_bin_d = peak_bin_q;
    peak_vld_d = 1'b0;

    // ---- peak search on each output transfer
    max_upd = xfer && bin_eligible(bin_p2_q) && (!have_max_q || (power_p2_q > max_pow_q));
    if (max_upd) begin
      have_max_d = 1'b1;
      max_pow_d  = power_p2_q;
      max_bin_d  = bin_p2_q;
    end

    if (state_q == REPORT) state_d = ACCUM;

    // Last bin closes the frame: publish the max including this bin and restart the search.
    if (xfer && (bin_p2_q == LAST_BIN)) begin
      peak_pow_d = max_upd ? power_p2_q : max_pow_q;
      peak_bin_d = max_upd ? bin_p2_q : max_bin_q;
      peak_vld_d = 1'b1;
      have_max_d = 1'b0;
      state_d    = REPORT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      bin_cnt_q  <= '0;
      power_p2_q <= '0;
      bin_p2_q   <= '0;
      state_q    <= ACCUM;
      have_max_q <= 1'b0;
      peak_pow_q <= '0;
      peak_bin_q <= '0;
      peak_vld_q <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      bin_cnt_q  <= bin_cnt_d;
      power_p2_q <= power_p2_d;
      bin_p2_q   <= bin_p2_d;
      state_q    <= state_d;
      have_max_q <= have_max_d;
      peak_pow_q <= peak_pow_d;
      peak_bin_q <= peak_bin_d;
      peak_vld_q <= peak_vld_d;
    end
  end

  // Datapath registers are qualified by the valid/have_max flags and need no reset.
  always_ff @(posedge clk_i) begin
    re_p1_q   <= re_p1_d;
    im_p1_q   <= im_p1_d;
    bin_p1_q  <= bin_p1_d;
    max_pow_q <= max_pow_d;
    max_bin_q <= max_bin_d;
  end

endmodule

// File: tb/tb_fft_power_peak.sv
// Self-checking bench for fft_power_peak: randomized stream against a frame-level reference model,
// two instances (SEARCH_HALF=1 and SEARCH_HALF=0) sharing the same stimulus.
`timescale 1ns/1ps
module tb_fft_power_peak;
  localparam int DW = 18;
  localparam int IW = 8;
  localparam int PW = 36;
  localparam int NB = 256;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, power_ready_i;
  logic [DW-1:0] data_real_i, data_imag_i;
  logic          ready_o, power_valid_o, peak_valid_o;
  logic [PW-1:0] power_o, peak_power_o;
  logic [IW-1:0] power_bin_o, peak_bin_o;
  logic          ready_f, power_valid_f, peak_valid_f;
  logic [PW-1:0] power_f, peak_power_f;
  logic [IW-1:0] power_bin_f, peak_bin_f;

  fft_power_peak #(.DATA_WIDTH(DW), .FFT_SIZE(NB), .IDX_WIDTH(IW), .SKIP_DC(1), .SEARCH_HALF(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
    .valid_i(valid_i), .ready_o(ready_o), .power_o(power_o), .power_bin_o(power_bin_o),
    .power_valid_o(power_valid_o), .power_ready_i(power_ready_i), .peak_bin_o(peak_bin_o),
    .peak_power_o(peak_power_o), .peak_valid_o(peak_valid_o));

  fft_power_peak #(.DATA_WIDTH(DW), .FFT_SIZE(NB), .IDX_WIDTH(IW), .SKIP_DC(1), .SEARCH_HALF(0)) dut_full (
    .clk_i(clk), .rst_i(rst_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
    .valid_i(valid_i), .ready_o(ready_f), .power_o(power_f), .power_bin_o(power_bin_f),
    .power_valid_o(power_valid_f), .power_ready_i(power_ready_i), .peak_bin_o(peak_bin_f),
    .peak_power_o(peak_power_f), .peak_valid_o(peak_valid_f));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ready_bad = 0;
  int mdl_bin = 0;
  int stim_re[512];
  int stim_im[512];
  longint frame_pw[NB];

  logic [PW-1:0]    exp_pow[$], obs_pow[$];
  logic [IW-1:0]    exp_bin[$], obs_bin[$];
  int               acc_cyc[$], obs_cyc[$];
  logic [IW+PW-1:0] exp_pk_h[$], exp_pk_f[$], obs_pk_h[$], obs_pk_f[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (power_valid_o && power_ready_i) begin
        obs_pow.push_back(power_o);
        obs_bin.push_back(power_bin_o);
        obs_cyc.push_back(cyc);
      end
      if (peak_valid_o) obs_pk_h.push_back({peak_bin_o, peak_power_o});
      if (peak_valid_f) obs_pk_f.push_back({peak_bin_f, peak_power_f});
      if (ready_o !== !(power_valid_o && !power_ready_i)) ready_bad++;
      if (ready_f !== ready_o || power_valid_f !== power_valid_o) ready_bad++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic clear_all();
    exp_pow.delete(); obs_pow.delete(); exp_bin.delete(); obs_bin.delete();
    acc_cyc.delete(); obs_cyc.delete();
    exp_pk_h.delete(); exp_pk_f.delete(); obs_pk_h.delete(); obs_pk_f.delete();
  endtask

  task automatic zero_stim();
    for (int i = 0; i < 512; i++) begin stim_re[i] = 0; stim_im[i] = 0; end
  endtask

  task automatic random_stim(input int from, input int to);
    for (int i = from; i < to; i++) begin
      stim_re[i] = int'($urandom_range(262143)) - 131072;
      stim_im[i] = int'($urandom_range(262143)) - 131072;
    end
  endtask

  // Reference model: exact power per accepted bin; a frame's peak is found over the whole
  // stored frame once its last bin is accepted (lowest bin wins ties, DC always skipped).
  task automatic model_accept(input int re, input int im);
    longint p;
    int best;
    longint bp;
    p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    exp_pow.push_back(PW'(p));
    exp_bin.push_back(IW'(mdl_bin));
    acc_cyc.push_back(cyc);
    frame_pw[mdl_bin] = p;
    if (mdl_bin == NB - 1) begin
      for (int h = 0; h < 2; h++) begin
        best = -1; bp = 0;
        for (int b = 1; b < NB; b++) begin
          if (h == 0 && b >= NB / 2) continue;
          if (best < 0 || frame_pw[b] > bp) begin best = b; bp = frame_pw[b]; end
        end
        if (h == 0) exp_pk_h.push_back({IW'(best), PW'(bp)});
        else        exp_pk_f.push_back({IW'(best), PW'(bp)});
      end
    end
    mdl_bin = (mdl_bin + 1) % NB;
  endtask

  task automatic drive_bins(input int n, input int rdy_pct, input int vld_pct);
    int  i;
    int  guard;
    logic acc;
    i = 0; guard = 0;
    while (i < n && guard < 5000) begin
      valid_i       = ($urandom_range(99) < vld_pct);
      data_real_i   = DW'(stim_re[i]);
      data_imag_i   = DW'(stim_im[i]);
      power_ready_i = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      acc = valid_i && ready_o;
      if (acc) model_accept(stim_re[i], stim_im[i]);
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    valid_i = 1'b0;
    if (i < n) begin
      n_checks++;
      $display("FAIL drive_timeout: accepted %0d bins, required %0d", i, n);
    end
  endtask

  task automatic drain();
    valid_i = 1'b0;
    power_ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; valid_i = 1'b0; power_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    mdl_bin = 0;
    clear_all();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %0b want 1", ready_o); else n_pass++;
    n_checks++; if (power_valid_o !== 1'b0) $display("FAIL reset_power_valid: got %0b want 0", power_valid_o); else n_pass++;
    n_checks++; if (power_o !== '0) $display("FAIL reset_power: got %0d want 0", power_o); else n_pass++;
    n_checks++; if (power_bin_o !== '0) $display("FAIL reset_power_bin: got %0d want 0", power_bin_o); else n_pass++;
    n_checks++; if (peak_valid_o !== 1'b0) $display("FAIL reset_peak_valid: got %0b want 0", peak_valid_o); else n_pass++;
    n_checks++; if (peak_bin_o !== '0) $display("FAIL reset_peak_bin: got %0d want 0", peak_bin_o); else n_pass++;
    n_checks++; if (peak_power_o !== '0) $display("FAIL reset_peak_power: got %0d want 0", peak_power_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  // Frame A: single tone at bin 37. Frame B (back-to-back): full-scale negative at bin 3.
  task automatic test_single_peak();
    int bad, first;
    clear_all(); zero_stim();
    stim_re[37] = 1000; stim_im[37] = -2000;
    stim_re[NB + 3] = -131072; stim_im[NB + 3] = -131072;
    drive_bins(2 * NB, 100, 100);
    drain();
    n_checks++; if (obs_pow.size() != 2 * NB) $display("FAIL single_count: got %0d outputs want %0d", obs_pow.size(), 2 * NB); else n_pass++;
    n_checks++; if (obs_pow[37] !== 36'd5000000 || obs_bin[37] !== 8'd37) $display("FAIL single_bin37: got bin %0d pow %0d want bin 37 pow 5000000", obs_bin[37], obs_pow[37]); else n_pass++;
    n_checks++; if (obs_pow[NB + 3] !== 36'h8_0000_0000) $display("FAIL fullscale_bin3: got pow %0d want 34359738368", obs_pow[NB + 3]); else n_pass++;
    bad = 0; first = 0;
    for (int k = 0; k < obs_pow.size() && k < acc_cyc.size(); k++)
      if (obs_cyc[k] - acc_cyc[k] != 2 || obs_bin[k] !== IW'(k % NB)) begin if (bad == 0) first = k; bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL single_latency: %0d bad, first k=%0d latency %0d bin %0d want latency 2 bin %0d", bad, first, obs_cyc[first] - acc_cyc[first], obs_bin[first], first % NB);
    else n_pass++;
    n_checks++; if (obs_pk_h.size() != 2) $display("FAIL single_peak_count: got %0d pulses want 2", obs_pk_h.size()); else n_pass++;
    n_checks++; if (obs_pk_h[0] !== {8'd37, 36'd5000000}) $display("FAIL peak_bin37: got bin %0d pow %0d want bin 37 pow 5000000", obs_pk_h[0][PW+:IW], obs_pk_h[0][PW-1:0]); else n_pass++;
    n_checks++; if (obs_pk_h[1] !== {8'd3, 36'h8_0000_0000}) $display("FAIL peak_bin3: got bin %0d pow %0d want bin 3 pow 34359738368", obs_pk_h[1][PW+:IW], obs_pk_h[1][PW-1:0]); else n_pass++;
    n_checks++; if (obs_pk_f.size() != 2 || obs_pk_f[1] !== {8'd3, 36'h8_0000_0000}) $display("FAIL peak_bin3_full: got %0d pulses last bin %0d want 2 pulses bin 3", obs_pk_f.size(), obs_pk_f[1][PW+:IW]); else n_pass++;
  endtask

  task automatic test_random_stall();
    int bad, first;
    clear_all(); zero_stim(); random_stim(0, NB);
    ready_bad = 0;
    drive_bins(NB, 50, 85);
    drain();
    n_checks++; if (obs_pow.size() != NB) $display("FAIL rand_count: got %0d outputs want %0d", obs_pow.size(), NB); else n_pass++;
    bad = 0; first = 0;
    for (int k = 0; k < obs_pow.size() && k < exp_pow.size(); k++)
      if (obs_pow[k] !== exp_pow[k] || obs_bin[k] !== exp_bin[k] || obs_bin[k] !== IW'(k)) begin if (bad == 0) first = k; bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL rand_stream: %0d bad, first k=%0d got bin %0d pow %0d want bin %0d pow %0d", bad, first, obs_bin[first], obs_pow[first], exp_bin[first], exp_pow[first]);
    else n_pass++;
    n_checks++; if (ready_bad != 0) $display("FAIL rand_ready: %0d cycles with wrong ready_o, want 0", ready_bad); else n_pass++;
    n_checks++; if (obs_pk_h.size() != 1 || obs_pk_h[0] !== exp_pk_h[0]) $display("FAIL rand_peak_half: got %0d pulses bin %0d pow %0d want 1 pulse bin %0d pow %0d", obs_pk_h.size(), obs_pk_h[0][PW+:IW], obs_pk_h[0][PW-1:0], exp_pk_h[0][PW+:IW], exp_pk_h[0][PW-1:0]); else n_pass++;
    n_checks++; if (obs_pk_f.size() != 1 || obs_pk_f[0] !== exp_pk_f[0]) $display("FAIL rand_peak_full: got %0d pulses bin %0d pow %0d want 1 pulse bin %0d pow %0d", obs_pk_f.size(), obs_pk_f[0][PW+:IW], obs_pk_f[0][PW-1:0], exp_pk_f[0][PW+:IW], exp_pk_f[0][PW-1:0]); else n_pass++;
  endtask

  task automatic test_skip_dc();
    clear_all(); zero_stim();
    stim_re[0]  = 90;  stim_im[0]  = 30;
    stim_re[10] = 20;  stim_im[10] = 10;
    stim_re[20] = -10; stim_im[20] = 20;
    drive_bins(NB, 70, 100);
    drain();
    n_checks++; if (obs_pow[0] !== 36'd9000) $display("FAIL dc_power: got %0d want 9000", obs_pow[0]); else n_pass++;
    n_checks++; if (obs_pk_h.size() != 1 || obs_pk_h[0] !== {8'd10, 36'd500}) $display("FAIL skip_dc_half: got %0d pulses bin %0d pow %0d want bin 10 pow 500", obs_pk_h.size(), obs_pk_h[0][PW+:IW], obs_pk_h[0][PW-1:0]); else n_pass++;
    n_checks++; if (obs_pk_f.size() != 1 || obs_pk_f[0] !== {8'd10, 36'd500}) $display("FAIL skip_dc_full: got %0d pulses bin %0d pow %0d want bin 10 pow 500", obs_pk_f.size(), obs_pk_f[0][PW+:IW], obs_pk_f[0][PW-1:0]); else n_pass++;
  endtask

  task automatic test_search_half();
    clear_all(); zero_stim();
    stim_re[200] = 300; stim_re[5] = 200;
    drive_bins(NB, 80, 90);
    drain();
    n_checks++; if (obs_pk_h.size() != 1 || obs_pk_h[0] !== {8'd5, 36'd40000}) $display("FAIL search_half_on: got %0d pulses bin %0d pow %0d want bin 5 pow 40000", obs_pk_h.size(), obs_pk_h[0][PW+:IW], obs_pk_h[0][PW-1:0]); else n_pass++;
    n_checks++; if (obs_pk_f.size() != 1 || obs_pk_f[0] !== {8'd200, 36'd90000}) $display("FAIL search_half_off: got %0d pulses bin %0d pow %0d want bin 200 pow 90000", obs_pk_f.size(), obs_pk_f[0][PW+:IW], obs_pk_f[0][PW-1:0]); else n_pass++;
  endtask

  task automatic test_abort_back_to_back();
    int bad, first;
    clear_all(); zero_stim(); random_stim(0, 100);
    drive_bins(100, 100, 100);
    apply_reset();
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b1 || power_valid_o !== 1'b0) $display("FAIL abort_reset_state: ready %0b valid %0b want 1 0", ready_o, power_valid_o); else n_pass++;
    @(posedge clk); #1;
    zero_stim();
    stim_re[37] = 1000; stim_im[37] = -2000;
    random_stim(NB, 2 * NB);
    drive_bins(2 * NB, 100, 100);
    drain();
    n_checks++; if (obs_pow.size() != 2 * NB) $display("FAIL abort_count: got %0d outputs want %0d", obs_pow.size(), 2 * NB); else n_pass++;
    bad = 0; first = 0;
    for (int k = 0; k < obs_pow.size() && k < exp_pow.size(); k++)
      if (obs_pow[k] !== exp_pow[k] || obs_bin[k] !== IW'(k % NB)) begin if (bad == 0) first = k; bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL abort_stream: %0d bad, first k=%0d got bin %0d pow %0d want bin %0d pow %0d", bad, first, obs_bin[first], obs_pow[first], first % NB, exp_pow[first]);
    else n_pass++;
    n_checks++; if (obs_pk_h.size() != 2) $display("FAIL abort_pulses: got %0d pulses want 2", obs_pk_h.size()); else n_pass++;
    n_checks++; if (obs_pk_h[0] !== {8'd37, 36'd5000000}) $display("FAIL abort_peak0: got bin %0d pow %0d want bin 37 pow 5000000", obs_pk_h[0][PW+:IW], obs_pk_h[0][PW-1:0]); else n_pass++;
    n_checks++; if (obs_pk_h[1] !== exp_pk_h[1] || obs_pk_f[1] !== exp_pk_f[1]) $display("FAIL abort_peak1: got bin %0d/%0d want bin %0d/%0d", obs_pk_h[1][PW+:IW], obs_pk_f[1][PW+:IW], exp_pk_h[1][PW+:IW], exp_pk_f[1][PW+:IW]); else n_pass++;
    n_checks++; if (ready_bad != 0) $display("FAIL ready_rule_total: %0d cycles with wrong ready_o, want 0", ready_bad); else n_pass++;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; power_ready_i = 1'b1;
    data_real_i = '0; data_imag_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    test_reset();
    test_single_peak();
    test_random_stall();
    test_skip_dc();
    test_search_half();
    test_abort_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
